sync_gen: RTL and testbench

SYNC_GEN -- requirements
Module: sync_gen

---
 rtl/sync_gen.sv | 172 +++++++++++++++++
 tb/tb_sync_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_gen.sv
// ADC conversion-start generator: programmable period/width sync pulse with
// continuous and burst modes, frame-boundary config updates.
//
// state | meaning
// IDLE  | sync low, waiting for enable (continuous) or start (burst)
// RUN   | phase counter cycling 0..P-1, sync high for cnt < W
module sync_gen #(
   parameter int CNT_W      = 16,
   parameter int BURST_W    = 16,
   parameter int DEF_PERIOD = 200,
   parameter int DEF_WIDTH  = 24
) (
   input  logic               clk_10m,
   input  logic               rst,
   input  logic               enable,
   input  logic               mode,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_width,
   input  logic               cfg_load,
   output logic               sync,
   output logic               sync_rise,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [BURST_W-1:0] sample_cnt
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   per_q, per_d, wid_q, wid_d;
   logic [CNT_W-1:0]   pper_q, pper_d, pwid_q, pwid_d;
   logic               pend_q, pend_d;
   logic               mode_q, mode_d;
   logic [BURST_W-1:0] left_q, left_d;
   logic [BURST_W-1:0] smp_q, smp_d;
   logic               sync_q, sync_d, rise_q, rise_d;
   logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic               cfg_ok, frame_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      wid_d   = wid_q;
      pper_d  = pper_q;
      pwid_d  = pwid_q;
      pend_d  = pend_q;
      mode_d  = mode_q;
      left_d  = left_q;
      smp_d   = smp_q;
      err_d   = err_q;
      done_d  = 1'b0;
      sync_d  = 1'b0;

      cfg_ok    = (cfg_period >= CNT_W'(2)) && (cfg_width != '0) && (cfg_width < cfg_period);
      frame_end = (state_q == RUN) && (cnt_q == per_q - CNT_W'(1));

      if (frame_end && pend_q) begin
         per_d  = pper_q;
         wid_d  = pwid_q;
         pend_d = 1'b0;
      end

      // A load landing on the boundary wins over an older pending one.
      if (cfg_load) begin
         if (cfg_ok) begin
            err_d = 1'b0;
            if (state_q == IDLE || frame_end) begin
               per_d  = cfg_period;
               wid_d  = cfg_width;
               pend_d = 1'b0;
            end else begin
               pper_d = cfg_period;
               pwid_d = cfg_width;
               pend_d = 1'b1;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable && !mode) begin
               state_d = RUN;
               mode_d  = 1'b0;
            end else if (enable && mode && start) begin
               if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  mode_d  = 1'b1;
                  left_d  = burst_len;
               end
            end
         end
         RUN: begin
            sync_d = (cnt_q < wid_q);
            if (cnt_q == '0) smp_d = smp_q + BURST_W'(1);
            if (frame_end) begin
               cnt_d = '0;
               if (mode_q) begin
                  left_d = left_q - BURST_W'(1);
                  if (left_q == BURST_W'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else if (!enable) begin
                     state_d = IDLE;
                  end
               end else if (!enable) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      rise_d = sync_d & ~sync_q;
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk_10m) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= CNT_W'(DEF_PERIOD);
         wid_q   <= CNT_W'(DEF_WIDTH);
         pper_q  <= '0;
         pwid_q  <= '0;
         pend_q  <= 1'b0;
         mode_q  <= 1'b0;
         left_q  <= '0;
         smp_q   <= '0;
         sync_q  <= 1'b0;
         rise_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         wid_q   <= wid_d;
         pper_q  <= pper_d;
         pwid_q  <= pwid_d;
         pend_q  <= pend_d;
         mode_q  <= mode_d;
         left_q  <= left_d;
         smp_q   <= smp_d;
         sync_q  <= sync_d;
         rise_q  <= rise_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign sync       = sync_q;
   assign sync_rise  = rise_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = err_q;
   assign sample_cnt = smp_q;

endmodule

// File: tb/tb_sync_gen.sv
// Bench for sync_gen: directed and randomized scenarios checked against a
// frame-level event model (expected rise/fall/busy/done edge numbers).
`timescale 1ns/1ps
module tb_sync_gen;

   logic        clk_10m = 1'b0;
   logic        rst = 1'b1, enable = 1'b0, mode = 1'b0, start = 1'b0, cfg_load = 1'b0;
   logic [15:0] burst_len = '0, cfg_period = '0, cfg_width = '0;
   logic        sync, sync_rise, busy, done, cfg_err;
   logic [15:0] sample_cnt;

   sync_gen dut (
      .clk_10m(clk_10m), .rst(rst), .enable(enable), .mode(mode), .start(start),
      .burst_len(burst_len), .cfg_period(cfg_period), .cfg_width(cfg_width),
      .cfg_load(cfg_load), .sync(sync), .sync_rise(sync_rise), .busy(busy),
      .done(done), .cfg_err(cfg_err), .sample_cnt(sample_cnt)
   );

   always #50 clk_10m = ~clk_10m;

   // Edge counter and event monitor: records the edge number after which each change is seen.
   int   cyc = 0;
   int   rise_bad = 0;
   logic prev_sync = 1'b0, prev_busy = 1'b0;
   int   rise_q[$], fall_q[$], done_q[$], bon_q[$], boff_q[$];

   always @(posedge clk_10m) cyc <= cyc + 1;

   always @(negedge clk_10m) begin
      if (sync && !prev_sync) rise_q.push_back(cyc);
      if (!sync && prev_sync) fall_q.push_back(cyc);
      if (busy && !prev_busy) bon_q.push_back(cyc);
      if (!busy && prev_busy) boff_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (cyc >= 2 && sync_rise !== (sync & ~prev_sync)) rise_bad <= rise_bad + 1;
      prev_sync <= sync;
      prev_busy <= busy;
   end

   int n_assert = 0, n_fail = 0;
   int exp_rise[$], exp_fall[$], exp_done[$], exp_bon[$], exp_boff[$];
   int nxt, exp_smp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_q(input string tag, input int a[$], input int b[$]);
      chk({tag, "_count"}, a.size(), b.size());
      if (a.size() == b.size())
         foreach (a[i]) chk($sformatf("%s[%0d]", tag, i), a[i], b[i]);
   endtask

   task automatic tick();
      @(posedge clk_10m);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   // Frame starting (cnt=0) after edge nxt: sync rises after nxt+1, falls after nxt+1+w.
   task automatic add_frame(input int p, input int w);
      exp_rise.push_back(nxt + 1);
      exp_fall.push_back(nxt + 1 + w);
      nxt += p;
      exp_smp++;
   endtask

   task automatic load_cfg(input int p, input int w);
      cfg_period = p[15:0];
      cfg_width  = w[15:0];
      cfg_load   = 1'b1;
      tick();
      cfg_load   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_smp = 0;
      tick();
   endtask

   initial begin
      int e, f, s, t, p, w, n, kind;

      // reset state
      repeat (3) tick();
      chk("rst_sync", sync, 0);
      chk("rst_rise", sync_rise, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_smp", sample_cnt, 0);
      rst = 1'b0;
      exp_smp = 0;
      tick();

      // continuous mode with defaults
      mode = 1'b0;
      enable = 1'b1;
      e = cyc;
      nxt = e + 1;
      exp_bon.push_back(nxt);
      repeat (5) add_frame(200, 24);
      wait_to(e + 1001);
      chk("smp_after_1000", sample_cnt, 5);

      // load mid-frame: current frame untouched, next frame uses 100/10
      f = nxt;
      wait_to(f + 50);
      load_cfg(100, 10);
      chk("err_valid_load", cfg_err, 0);
      add_frame(200, 24);

      f = nxt;
      wait_to(f + 30);
      load_cfg(20, 20);
      chk("err_w_eq_p", cfg_err, 1);
      add_frame(100, 10);

      // load on the last cycle of a frame takes effect immediately after it
      f = nxt;
      wait_to(f + 99);
      load_cfg(20, 5);
      chk("err_cleared", cfg_err, 0);
      add_frame(100, 10);
      add_frame(20, 5);

      // stop request mid-frame completes that frame
      f = nxt;
      wait_to(f + 10);
      enable = 1'b0;
      add_frame(20, 5);
      exp_boff.push_back(nxt);
      wait_to(nxt + 30);
      chk("stop_sync", sync, 0);
      chk("stop_busy", busy, 0);
      chk("cont_smp", sample_cnt, exp_smp[15:0]);

      // burst of 3 frames, with start/mode wiggles during RUN ignored
      do_reset();
      mode = 1'b1;
      enable = 1'b1;
      burst_len = 16'd3;
      tick();
      tick();
      chk("burst_wait_busy", busy, 0);
      s = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      nxt = s + 1;
      exp_bon.push_back(nxt);
      repeat (3) add_frame(200, 24);
      exp_boff.push_back(nxt);
      exp_done.push_back(nxt);
      wait_to(s + 100);
      mode = 1'b0;
      start = 1'b1;
      tick();
      mode = 1'b1;
      start = 1'b0;
      wait_to(nxt + 2);
      chk("burst_end_busy", busy, 0);
      chk("burst_smp", sample_cnt, exp_smp[15:0]);

      // zero-length burst: done only
      burst_len = 16'd0;
      t = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_done.push_back(t + 1);
      tick();
      tick();
      chk("len0_busy", busy, 0);

      // burst stopped early by enable: no done
      burst_len = 16'd5;
      s = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      nxt = s + 1;
      exp_bon.push_back(nxt);
      add_frame(200, 24);
      f = nxt;
      wait_to(f + 10);
      enable = 1'b0;
      add_frame(200, 24);
      exp_boff.push_back(nxt);
      wait_to(nxt + 5);
      chk("early_busy", busy, 0);

      // reset while sync high restores defaults
      cfg_period = 16'd50;
      cfg_width = 16'd20;
      cfg_load = 1'b1;
      mode = 1'b0;
      enable = 1'b1;
      t = cyc;
      tick();
      cfg_load = 1'b0;
      f = t + 1;
      exp_bon.push_back(f);
      wait_to(f + 2);
      load_cfg(0, 0);
      chk("err_p0", cfg_err, 1);
      wait_to(f + 5);
      rst = 1'b1;
      tick();
      exp_rise.push_back(f + 1);
      exp_fall.push_back(f + 6);
      exp_boff.push_back(f + 6);
      exp_smp = 0;
      chk("mid_rst_sync", sync, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", cfg_err, 0);
      chk("mid_rst_smp", sample_cnt, 0);
      chk("mid_rst_done", done, 0);
      rst = 1'b0;
      nxt = f + 7;
      exp_bon.push_back(nxt);
      f = nxt;
      wait_to(f + 10);
      enable = 1'b0;
      add_frame(200, 24);
      exp_boff.push_back(nxt);
      wait_to(nxt + 5);
      chk("post_rst_smp", sample_cnt, exp_smp[15:0]);

      // randomized bursts with random configs and rejected loads
      mode = 1'b1;
      enable = 1'b1;
      for (int it = 0; it < 6; it++) begin
         if (it == 0) begin
            p = 2;
            w = 1;
         end else begin
            p = $urandom_range(40, 2);
            w = $urandom_range(p - 1, 1);
         end
         n = $urandom_range(3, 1);
         load_cfg(p, w);
         chk($sformatf("rnd%0d_ok", it), cfg_err, 0);
         kind = $urandom_range(2, 0);
         if (kind == 0)      load_cfg($urandom_range(1, 0), 1);
         else if (kind == 1) load_cfg($urandom_range(40, 2), 0);
         else                load_cfg(p, $urandom_range(p + 5, p));
         chk($sformatf("rnd%0d_bad", it), cfg_err, 1);
         burst_len = n[15:0];
         s = cyc;
         start = 1'b1;
         tick();
         start = 1'b0;
         nxt = s + 1;
         exp_bon.push_back(nxt);
         repeat (n) add_frame(p, w);
         exp_boff.push_back(nxt);
         exp_done.push_back(nxt);
         wait_to(nxt + 3);
         chk($sformatf("rnd%0d_smp", it), sample_cnt, exp_smp[15:0]);
      end

      cmp_q("rise", rise_q, exp_rise);
      cmp_q("fall", fall_q, exp_fall);
      cmp_q("busy_on", bon_q, exp_bon);
      cmp_q("busy_off", boff_q, exp_boff);
      cmp_q("done", done_q, exp_done);
      chk("sync_rise_rule", rise_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
